// File: rtl/mac_array.sv
// mac_array: multi-lane signed multiply-accumulate engine.
// Three-stage pipeline: lane products, registered adder tree,
// saturating accumulate with per-vector result, sat flag and
// beat count.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   clear      synchronous flush, active-high
//   in_valid   beat present
//   in_last    final beat of vector (qualified by in_valid)
//   in_a,in_b  LANES packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid  one-cycle pulse per completed vector
//   out_acc    signed saturated vector result
//   out_sat    some accumulate step of the vector clamped
//   out_count  beats in the vector, saturating
module mac_array #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   input  logic                       in_last,
   input  logic [LANES*DATA_W-1:0]    in_a,
   input  logic [LANES*DATA_W-1:0]    in_b,
   output logic                       out_valid,
   output logic signed [ACC_W-1:0]    out_acc,
   output logic                       out_sat,
   output logic [CNT_W-1:0]           out_count
);

   localparam int PW    = 2 * DATA_W;
   localparam int SUM_W = PW + $clog2(LANES);

   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      {1'b1, {(ACC_W-1){1'b0}}};

   // S1
   logic signed [PW-1:0]    prod [LANES];
   logic signed [PW-1:0]    p1   [LANES];
   logic                    v1;
   logic                    l1;

   // S2
   logic signed [SUM_W-1:0] sum_c;
   logic signed [SUM_W-1:0] s2;
   logic                    v2;
   logic                    l2;

   // S3
   logic signed [ACC_W-1:0] acc;
   logic                    sat;
   logic [CNT_W-1:0]        cnt;
   logic                    first;

   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W:0]   nxt;
   logic                    ovf;
   logic signed [ACC_W-1:0] acc_c;
   logic                    sat_c;
   logic [CNT_W-1:0]        cnt_c;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod[i] = PW'($signed(in_a[i*DATA_W +: DATA_W]))
                 * PW'($signed(in_b[i*DATA_W +: DATA_W]));
      end
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + SUM_W'(p1[i]);
      end
   end

   // One guard bit: base and sum both fit ACC_W bits, so the
   // ACC_W+1 bit sum never wraps and the top two bits expose
   // overflow and its direction.
   always_comb begin
      base  = first ? '0 : acc;
      nxt   = (ACC_W+1)'(base) + (ACC_W+1)'(s2);
      ovf   = nxt[ACC_W] ^ nxt[ACC_W-1];
      if (!ovf)
         acc_c = nxt[ACC_W-1:0];
      else if (nxt[ACC_W])
         acc_c = ACC_MIN;
      else
         acc_c = ACC_MAX;
      sat_c = (!first && sat) || ovf;
      if (first)
         cnt_c = CNT_W'(1);
      else if (&cnt)
         cnt_c = cnt;
      else
         cnt_c = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) p1[i] <= '0;
         v1        <= 1'b0;
         l1        <= 1'b0;
         s2        <= '0;
         v2        <= 1'b0;
         l2        <= 1'b0;
         acc       <= '0;
         sat       <= 1'b0;
         cnt       <= '0;
         first     <= 1'b1;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_sat   <= 1'b0;
         out_count <= '0;
      end else if (clear) begin
         // output data registers deliberately hold
         v1        <= 1'b0;
         l1        <= 1'b0;
         v2        <= 1'b0;
         l2        <= 1'b0;
         acc       <= '0;
         sat       <= 1'b0;
         cnt       <= '0;
         first     <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         v1 <= in_valid;
         l1 <= in_valid && in_last;
         if (in_valid) begin
            for (int i = 0; i < LANES; i++) p1[i] <= prod[i];
         end
         v2 <= v1;
         l2 <= v1 && l1;
         if (v1) s2 <= sum_c;
         out_valid <= v2 && l2;
         if (v2) begin
            acc   <= acc_c;
            sat   <= sat_c;
            cnt   <= cnt_c;
            first <= l2;
            if (l2) begin
               out_acc   <= acc_c;
               out_sat   <= sat_c;
               out_count <= cnt_c;
            end
         end
      end
   end

endmodule

// File: doc/mac_array.md
# mac_array

Parametrised multi-lane multiply-accumulate engine, the next-generation replacement for the single-lane 32-bit MAC in the accelerator cores. Each accepted beat multiplies LANES signed operand pairs, reduces the products through a registered adder, and accumulates into a wide saturating accumulator. A vector is a run of beats terminated by `in_last`. At the end of each vector the block emits one result, a saturation flag and a beat count, then restarts the accumulator with no bubble.

## Interface
- `DATA_W`, 16: signed operand width per lane.
- `LANES`, 4: lanes per beat, ≥1.
- `ACC_W`, 40: accumulator and result width. Must satisfy ACC_W ≥ 2*DATA_W + clog2(LANES).
- `CNT_W`, 16: beat-counter width.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `clear` input 1: synchronous flush, active-high.
- `in_valid` input 1: beat present.
- `in_last` input 1: beat is the final beat of its vector. Qualified by `in_valid`.
- `in_a` input LANES*DATA_W: signed operands. Lane i occupies bits [i*DATA_W +: DATA_W].
- `in_b` input LANES*DATA_W: signed operands, same packing as `in_a`.
- `out_valid` output 1: one-cycle pulse per completed vector.
- `out_acc` output ACC_W: signed saturated vector result.
- `out_sat` output 1: set if any accumulation step of the vector clamped.
- `out_count` output CNT_W: beats in the vector, saturating at 2^CNT_W-1.

## Operation
- There is no backpressure. A beat is accepted on every edge where `in_valid`=1, `clear`=0 and `rst`=1.
- S1 stage: registers LANES products, each 2*DATA_W bits signed, together with the valid and last flags.
- S2 stage: registers the signed sum of the products, sign-extended to SUM_W = 2*DATA_W + clog2(LANES), together with the valid and last flags.
- S3 stage (accumulate, saturation and count):
  - Base value: 0 if the `first` flag is set, otherwise the running accumulator.
  - Next value: base + sign-extended sum, computed at ACC_W+1 bits.
  - Clamp: if the next value exceeds 2^(ACC_W-1)-1 it is replaced by that maximum. If it is below -2^(ACC_W-1) it is replaced by that minimum.
  - Accumulation continues from the clamped value (per-step saturation).
  - The sticky `sat` flag ORs in any clamp event. `first` resets `sat`.
  - The beat counter loads 1 when `first` is set, otherwise increments. It saturates at its maximum.
  - The `first` flag is set by reset, by `clear` and by any S3 beat with last=1. It is cleared by an S3 beat with last=0.
- Output register: on an S3 beat with last=1, the block loads `out_acc`, `out_sat` (including this step's clamp) and `out_count` (including this beat), and sets `out_valid`. Otherwise `out_valid`=0 and the data outputs hold their previous values.
- Back-to-back vectors are supported. The first beat of the next vector may be accepted on the edge after the previous vector's last beat.
- Single-beat vectors (`in_last`=1 on every beat) yield out_acc = clamp(sum) and out_count = 1 per beat.
- `clear`:
  - Zeroes all pipeline valid flags, the accumulator, the counter and the `sat` flag, and sets `first`.
  - Output data registers hold. `out_valid`=0 on the following cycle.
  - A beat presented together with `clear` is dropped. In-flight beats are discarded.
- `rst` low mid-vector: same as `clear`, and in addition all outputs reset.

## Timing
- Reset values: `out_valid`=0, `out_acc`=0, `out_sat`=0, `out_count`=0. All stage registers are 0 and `first`=1.
- Latency: a beat accepted at edge k is in S1 after k, in S2 after k+1 and in S3/output after k+2.
  - If that beat is last, `out_valid`=1 during the cycle between edges k+2 and k+3.
- Throughput: one beat per cycle. At most one `out_valid` pulse per cycle.
- `in_last` without `in_valid` is ignored.

## Test plan
- Basic dot product (defaults):
  - Stimulus: beat 1 with a={1,2,3,4}, b={5,6,7,8}, last=0, then beat 2 with the same operands, last=1.
  - Response: out_valid=1 exactly 3 cycles after beat 2, out_acc=140, out_count=2, out_sat=0.
- Back-to-back single-beat vectors:
  - Stimulus: three consecutive beats with last=1: a={1,1,1,1} with b={1,1,1,1}, then b={-2,-2,-2,-2}, then b={0,0,0,0}.
  - Response: three consecutive out_valid pulses with out_acc 4, -8, 0 and out_count=1 each.
- Positive saturation (ACC_W=34):
  - Stimulus: two beats of a=b={-32768 ×4}, second beat last.
  - Response: out_acc=8589934591, out_sat=1.
- Negative saturation (ACC_W=34):
  - Stimulus: three beats of a={-32768 ×4}, b={32767 ×4}, third beat last.
  - Response: out_acc=-8589934592, out_sat=1.
  - Next vector: a single beat with a=b={1,...} gives out_acc=4, out_sat=0.
- Clear and reset mid-vector:
  - Stimulus: two beats with last=0, then `clear`=1 together with a third beat, then one beat a={1,2,3,4}, b={1,1,1,1}, last=1.
  - Response: the only out_valid pulse carries out_acc=10, out_count=1.
  - Repeat with `rst` low instead of `clear`: all outputs read 0 on the cycle after reset.
- Counter saturation (CNT_W=2):
  - Stimulus: a 6-beat vector.
  - Response: out_count=3.
